// File: rtl/serial_pkg.sv
// Shared line levels and FSM state encoding for serial_rx and its serializer.
// SERIAL_RX_PARITY_EN adds the PARITY state to the encoding.
package serial_pkg;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/serial_rx.sv
// Serial frame receiver: start 1, WIDTH data bits MSB first, stop 0.
// Ports: clk, rst_n (async low), i_bit line in; o_data last good word,
// o_data_vld / o_frame_err one-cycle pulses, o_busy while not IDLE.
// Macro SERIAL_RX_PARITY_EN inserts an even-parity bit before stop.
module serial_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_vld,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             bad;

`ifdef SERIAL_RX_PARITY_EN
  logic par_err;
  assign bad = par_err;
`else
  assign bad = 1'b0;
`endif

  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_data_vld  <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      o_data_vld  <= 1'b0;
      o_frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_bit == START_LVL) begin
            state <= ST_DATA;
            cnt   <= '0;
          end
        end
        ST_DATA: begin
          shreg <= {shreg[WIDTH-2:0], i_bit};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            state <= ST_PARITY;
`else
            state <= ST_STOP;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY: begin
          // even parity: data plus parity bit must XOR to zero
          par_err <= ^{shreg, i_bit};
          state   <= ST_STOP;
        end
`endif
        ST_STOP: begin
          // always back to IDLE; a bad stop 1 is not a start bit
          state <= ST_IDLE;
          if (i_bit == STOP_LVL && !bad) begin
            o_data     <= shreg;
            o_data_vld <= 1'b1;
          end else begin
            o_frame_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
